// File: rtl/vc_allocator.sv
// Output-VC allocator: grants at most one requesting input VC per cycle a free output VC,
// using round-robin input selection and lowest-index-first output VC selection.
module vc_allocator #(
    parameter int VC_WIDTH = 1,
    parameter int NINPUTS  = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NINPUTS-1:0]         ivc_req,
    input  logic                       ovc_release,
    input  logic [VC_WIDTH-1:0]        release_vc,
    output logic                       allocate_enable,
    output logic [NINPUTS-1:0]         ivc_sel,
    output logic [VC_WIDTH-1:0]        allocated_vc,
    output logic [(1<<VC_WIDTH)-1:0]   ovc_busy
);

    localparam int NOVCS = 1 << VC_WIDTH;
    localparam int PTR_W = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
    localparam int CW    = PTR_W + 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NINPUTS-1:0] eligible;
    logic               vc_free;
    logic [VC_WIDTH-1:0] free_vc;
    logic               found;
    logic [PTR_W-1:0]   grant_idx;
    logic [CW-1:0]      cand;
    logic               grant;
    logic [NINPUTS-1:0] sel_next;
    logic [NOVCS-1:0]   busy_next;

    always_comb begin
        // ivc_sel is all zero whenever allocate_enable is low, so it masks directly
        eligible = ivc_req & ~ivc_sel;

        vc_free = 1'b0;
        free_vc = '0;
        for (int k = NOVCS - 1; k >= 0; k--) begin
            if (!ovc_busy[k]) begin
                vc_free = 1'b1;
                free_vc = VC_WIDTH'(k);
            end
        end

        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int o = 0; o < NINPUTS; o++) begin
            cand = CW'(rr_ptr) + CW'(o);
            if (cand >= CW'(NINPUTS)) begin
                cand = cand - CW'(NINPUTS);
            end
            if (!found && eligible[cand[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end

        grant = found && vc_free;

        sel_next = '0;
        if (grant) begin
            sel_next[grant_idx] = 1'b1;
        end

        // clear before set: a release never frees its VC for this cycle's allocation
        busy_next = ovc_busy;
        if (ovc_release) begin
            busy_next[release_vc] = 1'b0;
        end
        if (grant) begin
            busy_next[free_vc] = 1'b1;
        end

        ptr_next = rr_ptr;
        if (grant) begin
            ptr_next = (grant_idx == PTR_W'(NINPUTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            allocate_enable <= 1'b0;
            ivc_sel         <= '0;
            allocated_vc    <= '0;
            ovc_busy        <= '0;
            rr_ptr          <= '0;
        end else begin
            allocate_enable <= grant;
            ivc_sel         <= sel_next;
            allocated_vc    <= grant ? free_vc : '0;
            ovc_busy        <= busy_next;
            rr_ptr          <= ptr_next;
        end
    end

endmodule
